// File: rtl/vga_ball_ctrl.sv
// ============================================================================
// Module   : vga_ball_ctrl
// Purpose  : Bouncing-ball position/colour controller for a VGA overlay.
//            One position update per frame, started by the vys rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_ball_ctrl #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int RADIUS = 50,
    parameter int STEP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vys,
    input  logic        pause,
    output logic [9:0]  cx,
    output logic [9:0]  cy,
    output logic [15:0] ball_rgb,
    output logic        frame_tick
);

    // 11-bit bounds so centre + STEP can never wrap
    localparam logic [10:0] c_x_hi   = 11'(H_ACT - 1 - RADIUS);
    localparam logic [10:0] c_y_hi   = 11'(V_ACT - 1 - RADIUS);
    localparam logic [10:0] c_lo     = 11'(RADIUS);
    localparam logic [10:0] c_lo_thr = 11'(RADIUS + STEP);
    localparam logic [10:0] c_step   = 11'(STEP);
    localparam logic [9:0]  c_cx_rst = 10'(H_ACT / 2);
    localparam logic [9:0]  c_cy_rst = 10'(V_ACT / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_vys_d;
    logic        w_frame_edge;
    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [9:0]  r_nx;
    logic [9:0]  r_ny;
    logic        r_ndir_x;
    logic        r_ndir_y;
    logic        r_hit_x;
    logic        r_hit_y;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_inc;
    logic [15:0] r_rgb;

    // Next position along one axis: returns {hit, new_dir, new_pos}
    function automatic logic [11:0] axis_next(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [10:0] hi);
        logic [10:0] p;
        logic [10:0] sum;
        logic [10:0] diff;
        p    = {1'b0, pos};
        sum  = p + c_step;
        diff = p - c_step;
        if (dir) begin
            if (sum > hi) axis_next = {1'b1, 1'b0, hi[9:0]};
            else          axis_next = {1'b0, 1'b1, sum[9:0]};
        end else begin
            if (p < c_lo_thr) axis_next = {1'b1, 1'b1, c_lo[9:0]};
            else              axis_next = {1'b0, 1'b0, diff[9:0]};
        end
    endfunction

    function automatic logic [15:0] palette(input logic [1:0] idx);
        case (idx)
            2'd0:    palette = 16'hF800;
            2'd1:    palette = 16'h07E0;
            2'd2:    palette = 16'h001F;
            default: palette = 16'hFFE0;
        endcase
    endfunction

    assign w_frame_edge = vys & ~r_vys_d;
    assign w_idx_inc    = r_idx + 2'd1;

    // vys delay register for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_vys_d <= 1'b0;
        else      r_vys_d <= vys;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // FSM next-state and commit strobe; edges outside IDLE are ignored
    always_comb begin
        w_next_state = r_state;
        frame_tick   = 1'b0;
        case (r_state)
            IDLE:    if (w_frame_edge) w_next_state = CALC_X;
            CALC_X:  w_next_state = CALC_Y;
            CALC_Y:  w_next_state = COMMIT;
            COMMIT: begin
                w_next_state = IDLE;
                frame_tick   = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Per-axis computation followed by a single atomic commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cx     <= c_cx_rst;
            r_cy     <= c_cy_rst;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_nx     <= c_cx_rst;
            r_ny     <= c_cy_rst;
            r_ndir_x <= 1'b1;
            r_ndir_y <= 1'b1;
            r_hit_x  <= 1'b0;
            r_hit_y  <= 1'b0;
            r_idx    <= 2'd0;
            r_rgb    <= 16'hF800;
        end else begin
            case (r_state)
                CALC_X: {r_hit_x, r_ndir_x, r_nx} <= axis_next(r_cx, r_dir_x, c_x_hi);
                CALC_Y: {r_hit_y, r_ndir_y, r_ny} <= axis_next(r_cy, r_dir_y, c_y_hi);
                COMMIT: begin
                    if (!pause) begin
                        r_cx    <= r_nx;
                        r_cy    <= r_ny;
                        r_dir_x <= r_ndir_x;
                        r_dir_y <= r_ndir_y;
                        // A corner hit still advances the colour by one
                        if (r_hit_x | r_hit_y) begin
                            r_idx <= w_idx_inc;
                            r_rgb <= palette(w_idx_inc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cx       = r_cx;
    assign cy       = r_cy;
    assign ball_rgb = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_vga_ball_ctrl.sv
// ============================================================================
// Module   : tb_vga_ball_ctrl
// Purpose  : Directed bench for vga_ball_ctrl (default and corner-hit sizes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_ball_ctrl;

    logic        clk;
    logic        rst;
    logic        vys;
    logic        pause;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [15:0] ball_rgb;
    logic        frame_tick;
    logic [9:0]  cx2;
    logic [9:0]  cy2;
    logic [15:0] rgb2;
    logic        tick2;

    int errors   = 0;
    int checks   = 0;
    int tick_cnt = 0;
    int tick2_cnt = 0;
    int t0;

    vga_ball_ctrl u_dut (
        .clk(clk), .rst(rst), .vys(vys), .pause(pause),
        .cx(cx), .cy(cy), .ball_rgb(ball_rgb), .frame_tick(frame_tick)
    );

    // Square field: both axes reach the wall on the same frame
    vga_ball_ctrl #(.H_ACT(120), .V_ACT(120)) u_corner (
        .clk(clk), .rst(rst), .vys(vys), .pause(pause),
        .cx(cx2), .cy(cy2), .ball_rgb(rgb2), .frame_tick(tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick === 1'b1) tick_cnt++;
        if (tick2 === 1'b1)      tick2_cnt++;
    end

    // One complete frame: vys high 4 cycles, low 4 cycles
    task automatic frame();
        @(posedge clk); #1 vys = 1'b1;
        repeat (4) @(posedge clk);
        #1 vys = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; vys = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cx !== 10'd320 || cy !== 10'd240) begin
            errors++; $display("FAIL reset_pos: got %0d,%0d expected 320,240", cx, cy);
        end
        checks++;
        if (ball_rgb !== 16'hF800 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_rgb_tick: got %h,%b expected f800,0", ball_rgb, frame_tick);
        end
        checks++;
        if (cx2 !== 10'd60 || cy2 !== 10'd60) begin
            errors++; $display("FAIL reset_corner_pos: got %0d,%0d expected 60,60", cx2, cy2);
        end
        rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tick_cnt !== 0 || cx !== 10'd320) begin
            errors++; $display("FAIL idle_after_reset: got ticks=%0d cx=%0d expected 0,320", tick_cnt, cx);
        end
    endtask

    task automatic test_first_frame();
        @(posedge clk); #1 vys = 1'b1;
        @(posedge clk);               // vys_d captures edge, CALC_X
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL tick_calc_x: got %b expected 0", frame_tick);
        end
        @(posedge clk); @(negedge clk); // CALC_Y
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL tick_calc_y: got %b expected 0", frame_tick);
        end
        @(posedge clk); @(negedge clk); // COMMIT
        checks++;
        if (frame_tick !== 1'b1 || cx !== 10'd320) begin
            errors++; $display("FAIL tick_commit: got tick=%b cx=%0d expected 1,320", frame_tick, cx);
        end
        @(posedge clk); @(negedge clk); // committed
        checks++;
        if (frame_tick !== 1'b0 || cx !== 10'd322 || cy !== 10'd242 || ball_rgb !== 16'hF800) begin
            errors++; $display("FAIL first_frame: got tick=%b %0d,%0d %h expected 0 322,242 f800",
                               frame_tick, cx, cy, ball_rgb);
        end
        vys = 1'b0;
        repeat (4) @(posedge clk);
        checks++;
        if (tick_cnt !== 1) begin
            errors++; $display("FAIL first_tick_count: got %0d expected 1", tick_cnt);
        end
    endtask

    task automatic test_bounce();
        for (int f = 2; f <= 136; f++) begin
            frame();
            @(negedge clk);
            if (f == 94) begin
                checks++;
                if (cx !== 10'd508 || cy !== 10'd428) begin
                    errors++; $display("FAIL frame94: got %0d,%0d expected 508,428", cx, cy);
                end
            end
            if (f == 95) begin
                checks++;
                if (cx !== 10'd510 || cy !== 10'd429 || ball_rgb !== 16'h07E0) begin
                    errors++; $display("FAIL frame95_clamp: got %0d,%0d %h expected 510,429 07e0", cx, cy, ball_rgb);
                end
            end
            if (f == 96) begin
                checks++;
                if (cx !== 10'd512 || cy !== 10'd427) begin
                    errors++; $display("FAIL frame96_reverse: got %0d,%0d expected 512,427", cx, cy);
                end
            end
            if (f == 135) begin
                checks++;
                if (cx !== 10'd589 || cy !== 10'd349 || ball_rgb !== 16'h001F) begin
                    errors++; $display("FAIL frame135_xclamp: got %0d,%0d %h expected 589,349 001f", cx, cy, ball_rgb);
                end
            end
            if (f == 136) begin
                checks++;
                if (cx !== 10'd587 || cy !== 10'd347) begin
                    errors++; $display("FAIL frame136: got %0d,%0d expected 587,347", cx, cy);
                end
            end
            if (f == 4) begin
                checks++;
                if (cx2 !== 10'd68 || cy2 !== 10'd68 || rgb2 !== 16'hF800) begin
                    errors++; $display("FAIL corner_f4: got %0d,%0d %h expected 68,68 f800", cx2, cy2, rgb2);
                end
            end
            if (f == 5) begin
                checks++;
                if (cx2 !== 10'd69 || cy2 !== 10'd69 || rgb2 !== 16'h07E0) begin
                    errors++; $display("FAIL corner_hit: got %0d,%0d %h expected 69,69 07e0", cx2, cy2, rgb2);
                end
            end
            if (f == 6) begin
                checks++;
                if (cx2 !== 10'd67 || cy2 !== 10'd67 || rgb2 !== 16'h07E0) begin
                    errors++; $display("FAIL corner_reverse: got %0d,%0d %h expected 67,67 07e0", cx2, cy2, rgb2);
                end
            end
        end
    endtask

    task automatic test_pause();
        pause = 1'b1;
        t0 = tick_cnt;
        for (int i = 0; i < 10; i++) begin
            frame();
            @(negedge clk);
            checks++;
            if (cx !== 10'd587 || cy !== 10'd347 || ball_rgb !== 16'h001F) begin
                errors++; $display("FAIL pause_hold_%0d: got %0d,%0d %h expected 587,347 001f", i, cx, cy, ball_rgb);
            end
        end
        checks++;
        if (tick_cnt !== t0 + 10) begin
            errors++; $display("FAIL pause_ticks: got %0d expected %0d", tick_cnt - t0, 10);
        end
        pause = 1'b0;
    endtask

    task automatic test_pause_outside_commit();
        @(posedge clk); #1 vys = 1'b1; pause = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 pause = 1'b0;  // low again before COMMIT
        @(posedge clk);
        @(posedge clk); #1 pause = 1'b1;  // high again after COMMIT
        @(negedge clk);
        checks++;
        if (cx !== 10'd585 || cy !== 10'd345) begin
            errors++; $display("FAIL pause_outside_commit: got %0d,%0d expected 585,345", cx, cy);
        end
        vys = 1'b0; pause = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        t0 = tick_cnt;
        @(posedge clk); #1 vys = 1'b1;
        @(posedge clk); #1 vys = 1'b0;
        @(posedge clk); #1 vys = 1'b1;    // second edge while busy
        @(posedge clk); @(negedge clk);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL b2b_commit_timing: got %b expected 1", frame_tick);
        end
        repeat (8) @(posedge clk);
        #1 vys = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tick_cnt !== t0 + 1 || cx !== 10'd583 || cy !== 10'd343) begin
            errors++; $display("FAIL b2b_single_commit: got ticks=%0d %0d,%0d expected 1 583,343",
                               tick_cnt - t0, cx, cy);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 vys = 1'b1;
        @(posedge clk);
        @(posedge clk);                    // now in CALC_Y
        #1 rst = 1'b0;
        #1;
        checks++;
        if (cx !== 10'd320 || cy !== 10'd240 || ball_rgb !== 16'hF800 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %0d,%0d %h %b expected 320,240 f800 0",
                               cx, cy, ball_rgb, frame_tick);
        end
        vys = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        t0 = tick_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tick_cnt !== t0 || cx !== 10'd320 || cy !== 10'd240) begin
            errors++; $display("FAIL reset_abort: got ticks=%0d %0d,%0d expected 0 320,240",
                               tick_cnt - t0, cx, cy);
        end
        frame();
        @(negedge clk);
        checks++;
        if (cx !== 10'd322 || cy !== 10'd242 || ball_rgb !== 16'hF800 || tick_cnt !== t0 + 1) begin
            errors++; $display("FAIL post_reset_frame: got %0d,%0d %h ticks=%0d expected 322,242 f800 1",
                               cx, cy, ball_rgb, tick_cnt - t0);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_bounce();
        test_pause();
        test_pause_outside_commit();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (tick2_cnt !== tick_cnt) begin
            errors++; $display("FAIL corner_tick_count: got %0d expected %0d", tick2_cnt, tick_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
